// File: rtl/fire_control_pkg.sv
// Shared game constants for the fire-control slice.
//   GAME_CLK_HZ  : system clock frequency in Hz
//   fc_state_e   : fire-control FSM encoding (READY=0, COOLDOWN=1, RELOAD=2)
//   TIMER_W      : width of every cycle timer
package fire_control_pkg;

  localparam int GAME_CLK_HZ = 100_000_000;
  localparam int TIMER_W     = 32;

  typedef enum logic [1:0] {
    ST_READY    = 2'd0,
    ST_COOLDOWN = 2'd1,
    ST_RELOAD   = 2'd2
  } fc_state_e;

endpackage

// File: rtl/fire_control_if.sv
// Player-side signal bundle of the fire controller.
//   btn_fire  : raw, bouncing fire pushbutton (1 = pressed)
//   enable    : game-running qualifier
//   fire      : one-cycle shot pulse
//   ammo      : rounds remaining
//   reloading : reload timer running
//   ready     : a press would fire now
// master = game logic / stimulus side, slave = fire_control.
interface fire_control_if;
  logic       btn_fire;
  logic       enable;
  logic       fire;
  logic [3:0] ammo;
  logic       reloading;
  logic       ready;

  modport master (
    output btn_fire, enable,
    input  fire, ammo, reloading, ready
  );

  modport slave (
    input  btn_fire, enable,
    output fire, ammo, reloading, ready
  );
endinterface

// File: rtl/fire_control_btn_debounce.sv
// Two-flop synchronizer plus counting debouncer for one pushbutton.
//   clk, reset : system clock, asynchronous active-high reset
//   din        : raw asynchronous button input
//   level      : debounced button level
//   rise       : single-cycle pulse in the first cycle level is 1
// The level flips only after the synchronized input has disagreed with it
// for DEBOUNCE_CYC consecutive cycles; any agreeing cycle restarts the count.
module btn_debounce
  import fire_control_pkg::*;
#(
  parameter int DEBOUNCE_CYC = GAME_CLK_HZ / 100
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam logic [TIMER_W-1:0] DB_LAST = TIMER_W'(DEBOUNCE_CYC - 1);

  logic               sync1_q, sync2_q;
  logic               btn_db_q, btn_db_d;
  logic               rise_q, rise_d;
  logic [TIMER_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d    = '0;
    btn_db_d = btn_db_q;
    rise_d   = 1'b0;
    if (sync2_q != btn_db_q) begin
      if (cnt_q == DB_LAST) begin
        btn_db_d = sync2_q;
        rise_d   = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      btn_db_q <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= din;
      sync2_q  <= sync1_q;
      btn_db_q <= btn_db_d;
      rise_q   <= rise_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level = btn_db_q;
  assign rise  = rise_q;

endmodule

// File: rtl/fire_control.sv
// Fire controller: debounced fire button, per-shot cooldown, finite magazine
// with automatic timed reload.
//   clk, reset : system clock, asynchronous active-high reset
//   io (slave) : btn_fire, enable in; fire, ammo, reloading, ready out
// AMMO_MAX must lie in 1..15 (ammo is a 4-bit count).
module fire_control
  import fire_control_pkg::*;
#(
  parameter int CLK_HZ       = GAME_CLK_HZ,
  parameter int DEBOUNCE_CYC = CLK_HZ / 100,
  parameter int COOLDOWN_CYC = CLK_HZ / 5,
  parameter int AMMO_MAX     = 8,
  parameter int RELOAD_CYC   = CLK_HZ
) (
  input  logic           clk,
  input  logic           reset,
  fire_control_if.slave  io
);

  localparam logic [TIMER_W-1:0] COOL_LAST   = TIMER_W'(COOLDOWN_CYC - 1);
  localparam logic [TIMER_W-1:0] RELOAD_LAST = TIMER_W'(RELOAD_CYC - 1);
  localparam logic [3:0]         AMMO_FULL   = 4'(AMMO_MAX);

  logic db_level, db_rise, press;

  fc_state_e          state_q, state_d;
  logic [3:0]         ammo_q, ammo_d;
  logic               fire_q, fire_d;
  logic [TIMER_W-1:0] timer_q, timer_d;

  btn_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_btn_debounce (
    .clk   (clk),
    .reset (reset),
    .din   (io.btn_fire),
    .level (db_level),
    .rise  (db_rise)
  );

  // rise only ever fires alongside a settled high level; qualifying it keeps
  // the press event tied to the accepted button state.
  assign press = db_rise & db_level;

  // Timers run regardless of enable; only the shot decision looks at it.
  // The timer starts at 0 on the fire edge, so each timed state lasts exactly
  // its cycle count including the fire cycle.
  always_comb begin
    state_d = state_q;
    ammo_d  = ammo_q;
    fire_d  = 1'b0;
    timer_d = timer_q;
    case (state_q)
      ST_READY: begin
        timer_d = '0;
        if (press && io.enable && (ammo_q != 4'd0)) begin
          fire_d  = 1'b1;
          ammo_d  = ammo_q - 4'd1;
          state_d = (ammo_q == 4'd1) ? ST_RELOAD : ST_COOLDOWN;
        end
      end
      ST_COOLDOWN: begin
        if (timer_q == COOL_LAST) begin
          timer_d = '0;
          state_d = ST_READY;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_RELOAD: begin
        if (timer_q == RELOAD_LAST) begin
          timer_d = '0;
          state_d = ST_READY;
          ammo_d  = AMMO_FULL;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_READY;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_READY;
      ammo_q  <= AMMO_FULL;
      fire_q  <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      ammo_q  <= ammo_d;
      fire_q  <= fire_d;
      timer_q <= timer_d;
    end
  end

  assign io.fire      = fire_q;
  assign io.ammo      = ammo_q;
  assign io.reloading = (state_q == ST_RELOAD);
  assign io.ready     = (state_q == ST_READY) && (ammo_q != 4'd0) && io.enable;

endmodule

// File: doc/fire_control.md
FIRE_CONTROL -- requirements
Module: fire_control

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter DEBOUNCE_CYC, default CLK_HZ/100 (10 ms), number of consecutive stable cycles before a button level is accepted.
REQ-003 Parameter COOLDOWN_CYC, default CLK_HZ/5 (200 ms), minimum spacing between shots.
REQ-004 Parameter AMMO_MAX, default 8, magazine size; legal range 1..15.
REQ-005 Parameter RELOAD_CYC, default CLK_HZ (1 s), automatic reload duration.
REQ-006 Port clk, input, 1, system clock; all logic SHALL be clocked on its rising edge.
REQ-007 Port reset, input, 1, asynchronous, active-high reset.
REQ-008 Port btn_fire, input, 1, raw, asynchronous, bouncing fire pushbutton (1 = pressed).
REQ-009 Port enable, input, 1, game-running qualifier; presses are ignored while it is low.
REQ-010 Port fire, output, 1, one-cycle shot pulse that drives bullet spawn and the fire sound player.
REQ-011 Port ammo, output, 4, rounds remaining.
REQ-012 Port reloading, output, 1, high while the reload timer runs.
REQ-013 Port ready, output, 1, high when a press would fire now.

Function
REQ-014 btn_fire SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 Debounced level btn_db SHALL change only after the synchronized input has differed from btn_db for DEBOUNCE_CYC consecutive cycles; any agreeing cycle clears the count.
REQ-016 A press event SHALL be a single-cycle 0->1 transition of btn_db; a held button SHALL produce exactly one event.
REQ-017 The FSM SHALL have the states READY, COOLDOWN and RELOAD.
REQ-018 In READY, a press event with enable=1 and ammo>0 SHALL assert fire for exactly one cycle, starting at the next rising edge; ammo SHALL decrement on that same edge.
REQ-019 After a shot, the FSM SHALL enter RELOAD if the new ammo value is 0, and COOLDOWN otherwise.
REQ-020 COOLDOWN SHALL last exactly COOLDOWN_CYC cycles, counted from the fire cycle, and then return to READY.
REQ-021 RELOAD SHALL last exactly RELOAD_CYC cycles; on exit, ammo SHALL load AMMO_MAX in the same edge that enters READY.
REQ-022 Press events in COOLDOWN or RELOAD, or while enable=0, SHALL be discarded, not queued.
REQ-023 Timers SHALL keep running while enable=0.
REQ-024 reloading SHALL equal (state==RELOAD).
REQ-025 ready SHALL equal (state==READY && ammo>0 && enable).
REQ-026 Timer counters SHALL be 32 bits wide; ammo SHALL never underflow or exceed AMMO_MAX.
REQ-027 All outputs SHALL be registered or decoded only from registers; no combinational path SHALL exist from btn_fire or enable to fire.

Reset
REQ-028 Reset SHALL force state=READY, ammo=AMMO_MAX, fire=0, reloading=0, all counters=0, synchronizer flops=0 and btn_db=0.
REQ-029 Reset asserted mid-COOLDOWN or mid-RELOAD SHALL abort the timer; after release, ammo=AMMO_MAX and ready=enable.
REQ-030 A button held through reset release SHALL be debounced as a fresh press, yielding one shot.

Structure
REQ-031 The state encoding (READY=0, COOLDOWN=1, RELOAD=2) and CLK_HZ SHALL live in the shared game constants package/header.
REQ-032 The synchronizer and debouncer SHALL be a separate sub-module, btn_debounce (parameter DEBOUNCE_CYC; ports clk, reset, din, level, rise); fire_control SHALL instantiate it.

Verification
Bench parameters: DEBOUNCE_CYC=4, COOLDOWN_CYC=10, AMMO_MAX=3, RELOAD_CYC=20.
REQ-033 Glitch: btn_fire high for 3 cycles, then low -> no fire pulse; ammo stays 3.
REQ-034 Clean press held for 30 cycles -> exactly one fire pulse; ammo becomes 2; ready is low for 10 cycles and then returns high.
REQ-035 Second press during cooldown -> no fire; a press after READY is re-entered -> fire, ammo=1.
REQ-036 Third shot -> ammo=0; reloading is high for 20 cycles; a press during reload is ignored; then ammo=3 and ready=1.
REQ-037 A press with enable=0 -> no fire; ammo is unchanged.
REQ-038 Reset pulse asserted 5 cycles into reload -> reloading=0, ammo=3, fire=0 immediately after the reset edge.
